alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_arbiter_rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALUFN codes, legal-code table and FSM state encoding shared by the arbiter.
package alu_pkg;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100001;
  localparam logic [5:0] FN_CMPEQ = 6'b100100;
  localparam logic [5:0] FN_CMPLT = 6'b100101;
  localparam logic [5:0] FN_CMPLE = 6'b100110;
  localparam logic [5:0] FN_AND   = 6'b101000;
  localparam logic [5:0] FN_OR    = 6'b101001;
  localparam logic [5:0] FN_XOR   = 6'b101010;
  localparam logic [5:0] FN_XNOR  = 6'b101011;
  localparam logic [5:0] FN_SHL   = 6'b101100;
  localparam logic [5:0] FN_SHR   = 6'b101101;
  localparam logic [5:0] FN_SRA   = 6'b101110;
  localparam logic [5:0] LEGAL_FNS [12] = '{FN_ADD, FN_SUB, FN_CMPEQ, FN_CMPLT, FN_CMPLE,
    FN_AND, FN_OR, FN_XOR, FN_XNOR, FN_SHL, FN_SHR, FN_SRA};
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP} state_t;
endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; priority flips to the other requester on each advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr_q, ptr_d;
  assign grant[0] = valid[0] & (~valid[1] | ~ptr_q);
  assign grant[1] = valid[1] & (~valid[0] | ptr_q);
  assign ptr_d = advance ? grant[0] : ptr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters, one op in flight.
// Define ALU_ARB_FN_CHECK_EN to reject illegal ALUFN codes with rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int FW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [FW-1:0] req0_fn,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [FW-1:0] req1_fn,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  output logic [FW-1:0] alu_fn,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_y,
  output logic          rsp_err
);
  state_t        state_q, state_d;
  logic [FW-1:0] alu_fn_q, alu_fn_d;
  logic [DW-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_y_q, rsp_y_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_err_q, rsp_err_d;
  logic          id_q, id_d, err_q, err_d;
  logic [1:0]    grant;
  logic          idle, xfer, legal;
  logic [FW-1:0] fn_sel;
  logic [DW-1:0] a_sel, b_sel;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .valid({req1_valid, req0_valid}), .advance(xfer), .grant(grant));
  // rst_n gating keeps ready low while reset is held, even with valid high
  assign idle       = rst_n & (state_q == ST_IDLE);
  assign req0_ready = idle & grant[0];
  assign req1_ready = idle & grant[1];
  assign xfer       = req0_ready | req1_ready;
  assign fn_sel     = grant[1] ? req1_fn : req0_fn;
  assign a_sel      = grant[1] ? req1_a : req0_a;
  assign b_sel      = grant[1] ? req1_b : req0_b;
`ifdef ALU_ARB_FN_CHECK_EN
  always_comb begin
    legal = 1'b0;
    for (int i = 0; i < 12; i++) legal = legal | (fn_sel == FW'(LEGAL_FNS[i]));
  end
`else
  assign legal = 1'b1;
`endif
  always_comb begin
    state_d     = state_q;
    alu_fn_d    = alu_fn_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d     = rsp_y_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    id_d        = id_q;
    err_d       = err_q;
    if (xfer) begin
      state_d  = ST_ISSUE;
      alu_fn_d = legal ? fn_sel : '0;
      alu_a_d  = legal ? a_sel : '0;
      alu_b_d  = legal ? b_sel : '0;
      id_d     = grant[1];
      err_d    = ~legal;
    end else if (state_q == ST_ISSUE) begin
      state_d     = ST_RESP;
      rsp_valid_d = 1'b1;
      rsp_y_d     = err_q ? '0 : alu_y;
      rsp_id_d    = id_q;
      rsp_err_d   = err_q;
    end else if (state_q == ST_RESP && rsp_ready) begin
      state_d     = ST_IDLE;
      rsp_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_fn_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_fn_q    <= alu_fn_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      id_q        <= id_d;
      err_q       <= err_d;
    end
  assign alu_fn    = alu_fn_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and a random run against a queue model.
module tb_alu_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic v0 = 1'b0, v1 = 1'b0, r0, r1, rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_err;
  logic [5:0] fn0 = '0, fn1 = '0, alu_fn;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, alu_a, alu_b, alu_y, rsp_y;
  int nvec = 0, nerr = 0;
  always #5 clk = ~clk;

  alu_arbiter dut (.clk(clk), .rst_n(rst_n), .req0_valid(v0), .req0_ready(r0), .req0_fn(fn0),
    .req0_a(a0), .req0_b(b0), .req1_valid(v1), .req1_ready(r1), .req1_fn(fn1), .req1_a(a1),
    .req1_b(b1), .alu_fn(alu_fn), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err));

  function automatic logic [31:0] alu(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      6'b100000: return a + b;
      6'b100001: return a - b;
      6'b100100: return {31'b0, a == b};
      6'b100101: return {31'b0, $signed(a) < $signed(b)};
      6'b100110: return {31'b0, $signed(a) <= $signed(b)};
      6'b101000: return a & b;
      6'b101001: return a | b;
      6'b101010: return a ^ b;
      6'b101011: return ~(a ^ b);
      6'b101100: return a << b[4:0];
      6'b101101: return a >> b[4:0];
      6'b101110: return $signed(a) >>> b[4:0];
      default:   return 32'hDEADBEEF;
    endcase
  endfunction
  assign alu_y = alu(alu_fn, alu_a, alu_b);

  function automatic bit is_legal(input logic [5:0] f);
    return f inside {6'b100000, 6'b100001, 6'b100100, 6'b100101, 6'b100110, 6'b101000,
                     6'b101001, 6'b101010, 6'b101011, 6'b101100, 6'b101101, 6'b101110};
  endfunction
`ifdef ALU_ARB_FN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    v0 = 0; v1 = 0; rsp_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 0; idle_inputs();
    @(negedge clk); rst_n = 1;
  endtask

  typedef struct {
    bit who; logic [5:0] fn; logic [31:0] a, b, y; bit err;
  } vec_t;
  vec_t tbl[6];

  typedef struct { logic [31:0] y; bit id; bit err; } exp_t;
  exp_t q[$];

  initial begin
    bit busy, prio, er0, er1;
    int age;
    logic [5:0] f;
    tbl[0] = '{0, 6'b100000, 32'd15, 32'd13, 32'd28, 0};
    tbl[1] = '{1, 6'b101110, 32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF, 0};
    tbl[2] = '{0, 6'b101010, 32'hF0F0_1234, 32'h0FF0_0034, 32'hFF00_1200, 0};
    tbl[3] = '{1, 6'b101100, 32'h0000_0003, 32'd31, 32'h8000_0000, 0};
    tbl[4] = '{0, 6'b100100, 32'd7, 32'd7, 32'd1, 0};
    tbl[5] = '{1, 6'b100111, 32'd5, 32'd9, CHK ? 32'd0 : 32'hDEADBEEF, CHK};

    // reset state with both requesters asserting valid
    v0 = 1; v1 = 1;
    #12;
    chk("rst_ready", {r1, r0}, 2'b00);
    chk("rst_outs", {rsp_valid, rsp_id, rsp_err, rsp_y, alu_fn}, '0);
    chk("rst_alu", {alu_a, alu_b}, '0);
    v0 = 0; v1 = 0;
    @(negedge clk); rst_n = 1;

    // vector table: single requester, rsp_ready high
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      if (tbl[i].who) begin v1 = 1; fn1 = tbl[i].fn; a1 = tbl[i].a; b1 = tbl[i].b; end
      else begin v0 = 1; fn0 = tbl[i].fn; a0 = tbl[i].a; b0 = tbl[i].b; end
      @(negedge clk);
      chk("tbl_ready", {r1, r0}, tbl[i].who ? 2'b10 : 2'b01);
      @(posedge clk); #1; v0 = 0; v1 = 0;
      @(negedge clk);
      chk("tbl_issue_fn", alu_fn, tbl[i].err ? 6'd0 : tbl[i].fn);
      chk("tbl_issue_ab", {alu_a, alu_b}, tbl[i].err ? 64'd0 : {tbl[i].a, tbl[i].b});
      chk("tbl_issue_valid", rsp_valid, 0);
      @(negedge clk);
      chk("tbl_rsp", {rsp_valid, rsp_id, rsp_err, rsp_y}, {1'b1, tbl[i].who, tbl[i].err, tbl[i].y});
    end

    // both valid continuously: grants alternate 0,1,0
    do_reset();
    @(posedge clk); #1;
    v0 = 1; fn0 = 6'b100001; a0 = 15; b0 = 13;
    v1 = 1; fn1 = 6'b100101; a1 = 13; b1 = 15;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("alt_grant", {r1, r0}, k == 1 ? 2'b10 : 2'b01);
      @(negedge clk); chk("alt_busy", {r1, r0}, 2'b00);
      @(negedge clk);
      chk("alt_rsp", {rsp_valid, rsp_id, rsp_y}, {1'b1, k == 1, k == 1 ? 32'd1 : 32'd2});
    end
    @(posedge clk); #1; idle_inputs();

    // rsp_ready held low for 5 cycles after rsp_valid
    do_reset();
    @(posedge clk); #1; v0 = 1; fn0 = 6'b100000; a0 = 1; b0 = 2; rsp_ready = 0;
    @(posedge clk); #1; v0 = 0; v1 = 1; fn1 = 6'b101001; a1 = 32'h30; b1 = 32'h0C;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_rsp", {rsp_valid, rsp_id, rsp_err, rsp_y}, {3'b100, 32'd3});
      chk("hold_ready", {r1, r0}, 2'b00);
    end
    rsp_ready = 1;
    @(posedge clk); #1; rsp_ready = 0;
    @(negedge clk); chk("hold_next", {r1, r0}, 2'b10);
    @(posedge clk); #1; v1 = 0; rsp_ready = 1;
    @(negedge clk); @(negedge clk);
    chk("hold_next_rsp", {rsp_valid, rsp_id, rsp_y}, {2'b11, 32'h3C});
    @(posedge clk); #1;

    // reset pulsed during RESP
    do_reset();
    @(posedge clk); #1; v0 = 1; fn0 = 6'b100000; a0 = 100; b0 = 1; rsp_ready = 0;
    @(posedge clk); #1; v0 = 0;
    @(negedge clk); @(negedge clk);
    chk("prerst_rsp", {rsp_valid, rsp_y}, {1'b1, 32'd101});
    #1 rst_n = 0; #1;
    chk("async_rst", {rsp_valid, rsp_id, rsp_err, rsp_y, alu_fn, alu_a, alu_b}, '0);
    @(negedge clk); rst_n = 1; rsp_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); chk("postrst_norsp", rsp_valid, 0);
    end
    @(posedge clk); #1; v0 = 1; v1 = 1;
    @(negedge clk); chk("postrst_grant", {r1, r0}, 2'b01);
    @(posedge clk); #1; idle_inputs();

    // randomized traffic against the queue model
    do_reset();
    busy = 0; prio = 0; age = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      v0 = $urandom_range(0, 2) != 0; v1 = $urandom_range(0, 2) != 0;
      f = $urandom_range(0, 11) == 0 ? 6'b100111 : tbl[0].fn + 6'($urandom_range(0, 14));
      fn0 = f; fn1 = 6'b100000 + 6'($urandom_range(0, 15));
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      rsp_ready = $urandom_range(0, 3) != 0;
      @(negedge clk);
      if (busy) age++;
      er0 = !busy && v0 && (!v1 || !prio);
      er1 = !busy && v1 && (!v0 || prio);
      chk("rnd_ready", {r1, r0}, {er1, er0});
      chk("rnd_valid", rsp_valid, busy && age >= 2);
      if (busy && age >= 2) begin
        chk("rnd_rsp", {rsp_id, rsp_err, rsp_y}, {q[0].id, q[0].err, q[0].y});
        if (rsp_ready) begin void'(q.pop_front()); busy = 0; end
      end else if (er0 || er1) begin
        f = er1 ? fn1 : fn0;
        q.push_back('{(CHK && !is_legal(f)) ? 32'd0 : alu(f, er1 ? a1 : a0, er1 ? b1 : b0),
                      er1, CHK && !is_legal(f)});
        busy = 1; age = 0; prio = er0;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
